noise_adc_if: RTL and testbench
===============================

Name: noise_adc_if

Overview:
- Upstream front end of the noise acquisition path: drives the external 12-bit serial noise ADC (AD7476-class, 16-clock frame, 4 leading zeros) once per acquisition strobe.
- Deserialises each frame and presents a stable parallel sample on n_ADC.
- Sample is ready before the next rising edge of Noise_acq_clk, which writes it into the noise RAM.
- Runs entirely on clk_sys; Noise_acq_clk is derived from clk_sys, so it is treated as a synchronous strobe.

Parameters:
- SCLK_DIV, 4, clk_sys cycles per SCLK half-period (legal 2..15).
- DATA_W, 12, sample width.
- LEAD_Z, 4, leading zero bits per frame; frame length FRAME_BITS = DATA_W + LEAD_Z = 16.
- QUIET_CYC, 8, clk_sys cycles CS must stay high between frames.

Ports:
- clk_sys  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- conv_trig  in  1  acquisition strobe (Noise_acq_clk); a conversion starts on its rising edge.
- load  in  1  noise_load; a 1-cycle pulse clears the sticky flags.
- adc_sdo  in  1  ADC serial data.
- adc_cs_n  out  1  ADC chip select.
- adc_sclk  out  1  ADC serial clock, idles high.
- n_ADC  out  DATA_W  last captured sample.
- data_valid  out  1  1-cycle pulse when n_ADC updates.
- busy  out  1  frame in progress, including the quiet period.
- overrun  out  1  sticky: trigger arrived while busy.
- lead_err  out  1  sticky: a nonzero leading bit was seen.

Behaviour:
- Reset values: adc_cs_n=1, adc_sclk=1, n_ADC=0, data_valid=0, busy=0, overrun=0, lead_err=0, state=IDLE.
- Reset is asynchronous: assertion mid-frame drives CS and SCLK high immediately and discards the partial shift register.
- Trigger detection: conv_trig is registered once; rise = trig_q0 & ~trig_q1. Detection costs 1 cycle.
- State machine: IDLE -> SETUP -> SHIFT -> QUIET -> IDLE.
- IDLE: on rise, enter SETUP, drive adc_cs_n=0, assert busy.
- SETUP: wait SCLK_DIV cycles with SCLK high, then enter SHIFT.
- SHIFT: FRAME_BITS SCLK periods. Each period is SCLK low for SCLK_DIV cycles, then high for SCLK_DIV cycles.
- Bit sampling: adc_sdo is sampled in the last clk_sys cycle of each low phase and shifted in MSB-first. A 5-bit bit counter counts 0..15.
- After bit 15's high phase completes: adc_cs_n=1, n_ADC <= shift[DATA_W-1:0], data_valid pulses for exactly 1 cycle, enter QUIET.
- QUIET: hold for QUIET_CYC cycles, then go to IDLE and deassert busy.
- Latency, SCLK_DIV=4, QUIET_CYC=8:
  - conv_trig rise to adc_cs_n fall: 2 cycles.
  - CS fall to n_ADC update: 4 + 16*8 = 132 cycles.
  - Busy total: 140 cycles.
  - Minimum legal trigger period: 142 cycles.
- Overrun: a rise seen while busy is ignored (no restart, no effect on the current frame) and sets overrun.
- Lead-error: any 1 among the first LEAD_Z sampled bits sets lead_err. The sample is still delivered.
- Flag clear: load clears overrun and lead_err. If load coincides with a new flag event in the same cycle, the set wins.
- n_ADC holds its value between frames and never changes except on the data_valid cycle.
- Frames complete or are reset only; there is no abort input.

Decomposition:
- Package noise_acq_pkg holds:
  - state enum {IDLE, SETUP, SHIFT, QUIET};
  - constant FRAME_BITS;
  - default SCLK_DIV and QUIET_CYC.
- Sub-module noise_sclk_gen: half-period divider counter.
  - Inputs: clk_sys, rst_n, run.
  - Outputs: sclk, smp_tick (last cycle of low phase), end_tick (last cycle of high phase).
  - Held in reset state while run=0.

Test Plan:
- Reset then a single conv_trig rise, ADC model returning 0x0A5C -> adc_cs_n falls 2 cycles later, 16 SCLK falls, n_ADC=0xA5C, data_valid high for exactly 1 cycle, 132 cycles after CS fall.
- Trigger period 142 cycles for 4 frames with samples 0x000, 0xFFF, 0x800, 0x001 -> each captured exactly, overrun stays 0, CS high for at least 8 cycles between frames.
- Second rise 50 cycles into a frame -> frame unaffected, overrun=1, no extra frame. load pulse -> overrun=0.
- ADC drives leading bits 1010 with data 0x123 -> n_ADC=0x123, lead_err=1. load pulse coinciding with a new lead error -> lead_err stays 1.
- rst_n asserted at SCLK edge 7 -> adc_cs_n=1 and adc_sclk=1 asynchronously, n_ADC=0. Next trigger after release -> clean full frame.
- SCLK_DIV=2 build -> SCLK period 4 cycles, capture still correct, CS fall to data_valid 2+64 cycles.

Source files
------------

// File: rtl/noise_acq_pkg.sv
// rtl/noise_acq_pkg.sv - shared types and constants for the noise acquisition front end
// Contents: acq_state_t frame sequencer states, FRAME_BITS, default timing constants.
package noise_acq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    QUIET = 2'd3
  } acq_state_t;

  localparam int FRAME_BITS    = 16;
  localparam int DEF_LEAD_Z    = 4;
  localparam int DEF_SCLK_DIV  = 4;
  localparam int DEF_QUIET_CYC = 8;

endpackage

// File: rtl/noise_sclk_gen.sv
// rtl/noise_sclk_gen.sv - SCLK half-period divider for the serial noise ADC
// Ports:
//   clk_sys  in   system clock
//   rst_n    in   asynchronous active-low reset
//   run      in   0 holds the divider idle (SCLK high, counter cleared)
//   sclk     out  serial clock, idles high
//   smp_tick out  last clk_sys cycle of an SCLK low phase
//   end_tick out  last clk_sys cycle of an SCLK high phase
module noise_sclk_gen
  import noise_acq_pkg::*;
#(
  parameter int SCLK_DIV = DEF_SCLK_DIV
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic run,
  output logic sclk,
  output logic smp_tick,
  output logic end_tick
);

  localparam logic [3:0] LAST = 4'(SCLK_DIV - 1);

  logic [3:0] cnt;
  logic       half_done;

  // While idle cnt is 0 and LAST >= 1, so neither tick can fire.
  assign half_done = (cnt == LAST);
  assign smp_tick  = half_done & ~sclk;
  assign end_tick  = half_done & sclk;

  // The first phase after run rises is a high phase; the sequencer uses it
  // as the CS-to-first-falling-edge setup time.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= 4'd0;
      sclk <= 1'b1;
    end else if (!run) begin
      cnt  <= 4'd0;
      sclk <= 1'b1;
    end else if (half_done) begin
      cnt  <= 4'd0;
      sclk <= ~sclk;
    end else begin
      cnt  <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/noise_adc_if.sv
// rtl/noise_adc_if.sv - serial noise ADC frame driver and deserialiser
// Ports:
//   clk_sys    in   system clock
//   rst_n      in   asynchronous active-low reset
//   conv_trig  in   acquisition strobe, conversion starts on its rising edge
//   load       in   1-cycle pulse clearing overrun and lead_err
//   adc_sdo    in   ADC serial data
//   adc_cs_n   out  ADC chip select
//   adc_sclk   out  ADC serial clock, idles high
//   n_ADC      out  last captured sample
//   data_valid out  1-cycle pulse when n_ADC updates
//   busy       out  frame in progress, including the quiet period
//   overrun    out  sticky, trigger arrived while busy
//   lead_err   out  sticky, nonzero leading bit seen
module noise_adc_if
  import noise_acq_pkg::*;
#(
  parameter int SCLK_DIV  = DEF_SCLK_DIV,
  parameter int DATA_W    = FRAME_BITS - DEF_LEAD_Z,
  parameter int LEAD_Z    = DEF_LEAD_Z,
  parameter int QUIET_CYC = DEF_QUIET_CYC
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              conv_trig,
  input  logic              load,
  input  logic              adc_sdo,
  output logic              adc_cs_n,
  output logic              adc_sclk,
  output logic [DATA_W-1:0] n_ADC,
  output logic              data_valid,
  output logic              busy,
  output logic              overrun,
  output logic              lead_err
);

  localparam int NBITS = DATA_W + LEAD_Z;
  localparam int QW    = $clog2(QUIET_CYC + 1);

  acq_state_t        state;
  logic              trig_q0, trig_q1, rise;
  logic [4:0]        bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [QW-1:0]     qcnt;
  logic              run, smp_tick, end_tick, last_end, lead_hit;

  assign rise     = trig_q0 & ~trig_q1;
  assign busy     = (state != IDLE);
  assign last_end = end_tick && (bit_cnt == 5'(NBITS - 1));
  // Dropping run on the final end_tick keeps the divider from starting
  // another low phase; SCLK stays high as CS rises.
  assign run      = (state == SETUP) || ((state == SHIFT) && !last_end);
  assign lead_hit = (state == SHIFT) && smp_tick && adc_sdo && (bit_cnt < 5'(LEAD_Z));

  noise_sclk_gen #(
    .SCLK_DIV (SCLK_DIV)
  ) u_sclk_gen (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .run      (run),
    .sclk     (adc_sclk),
    .smp_tick (smp_tick),
    .end_tick (end_tick)
  );

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      trig_q0 <= 1'b0;
      trig_q1 <= 1'b0;
    end else begin
      trig_q0 <= conv_trig;
      trig_q1 <= trig_q0;
    end
  end

  // Only the low DATA_W bits are kept: the leading bits fall off the top
  // of the shift register and are checked separately via lead_hit.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      adc_cs_n   <= 1'b1;
      bit_cnt    <= 5'd0;
      shreg      <= '0;
      qcnt       <= '0;
      n_ADC      <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state    <= SETUP;
            adc_cs_n <= 1'b0;
            bit_cnt  <= 5'd0;
          end
        end
        SETUP: begin
          if (end_tick) state <= SHIFT;
        end
        SHIFT: begin
          if (smp_tick) shreg <= {shreg[DATA_W-2:0], adc_sdo};
          if (last_end) begin
            state      <= QUIET;
            adc_cs_n   <= 1'b1;
            n_ADC      <= shreg;
            data_valid <= 1'b1;
            qcnt       <= '0;
          end else if (end_tick) begin
            bit_cnt <= bit_cnt + 5'd1;
          end
        end
        QUIET: begin
          if (qcnt == QW'(QUIET_CYC - 1)) state <= IDLE;
          else qcnt <= qcnt + QW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A new flag event in the same cycle as load takes priority over the clear.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      overrun  <= 1'b0;
      lead_err <= 1'b0;
    end else begin
      if (rise && busy) overrun <= 1'b1;
      else if (load)    overrun <= 1'b0;
      if (lead_hit)     lead_err <= 1'b1;
      else if (load)    lead_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_noise_adc_if.sv
// tb/tb_noise_adc_if.sv - self-checking bench for noise_adc_if with a behavioural ADC model
module tb_noise_adc_if;

  localparam int DIV  = 4;
  localparam int QC   = 8;
  localparam int NB   = 16;
  localparam int DIV2 = 2;
  localparam int LAT  = DIV + NB * 2 * DIV;
  localparam int LAT2 = DIV2 + NB * 2 * DIV2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic        rst_n, conv_trig, load, adc_sdo;
  logic        adc_cs_n, adc_sclk, data_valid, busy, overrun, lead_err;
  logic [11:0] n_adc;

  logic        trig2, sdo2, cs2, sclk2, dv2, busy2, ov2, le2;
  logic [11:0] n_adc2;

  int checks = 0;
  int errors = 0;

  noise_adc_if u_dut (
    .clk_sys    (clk),
    .rst_n      (rst_n),
    .conv_trig  (conv_trig),
    .load       (load),
    .adc_sdo    (adc_sdo),
    .adc_cs_n   (adc_cs_n),
    .adc_sclk   (adc_sclk),
    .n_ADC      (n_adc),
    .data_valid (data_valid),
    .busy       (busy),
    .overrun    (overrun),
    .lead_err   (lead_err)
  );

  noise_adc_if #(.SCLK_DIV(DIV2)) u_dut2 (
    .clk_sys    (clk),
    .rst_n      (rst_n),
    .conv_trig  (trig2),
    .load       (1'b0),
    .adc_sdo    (sdo2),
    .adc_cs_n   (cs2),
    .adc_sclk   (sclk2),
    .n_ADC      (n_adc2),
    .data_valid (dv2),
    .busy       (busy2),
    .overrun    (ov2),
    .lead_err   (le2)
  );

  // ADC model: bit k of the 16-bit frame word (MSB first) is presented
  // after the k-th SCLK falling edge of the frame.
  logic [15:0] adc_word = 16'h0;
  int falls = 0, cs_falls = 0, rise_cyc = 0, min_gap = 1000;

  always @(negedge adc_cs_n) begin
    if (cyc - rise_cyc < min_gap) min_gap = cyc - rise_cyc;
    falls = 0;
    cs_falls++;
  end
  always @(posedge adc_cs_n) rise_cyc = cyc;
  always @(negedge adc_sclk) begin
    if (!adc_cs_n) begin
      if (falls < 16) adc_sdo = adc_word[15-falls];
      falls++;
    end
  end

  logic [15:0] word2 = 16'h0;
  int falls2 = 0, last_fall2 = 0, per2 = 0;
  always @(negedge cs2) falls2 = 0;
  always @(negedge sclk2) begin
    if (!cs2) begin
      if (falls2 < 16) sdo2 = word2[15-falls2];
      if (falls2 > 0) per2 = cyc - last_fall2;
      last_fall2 = cyc;
      falls2++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_load();
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  // Runs one frame from trigger to data_valid; entered and left at #1 after an edge.
  // period: edges from trigger to return (0 = return right after the pulse check).
  // inj_at/load_at: edge index after CS fall to raise a second trigger / pulse load.
  task automatic do_frame(input logic [15:0] w, input int period, input int inj_at,
                          input int load_at, input string tag);
    int n, m;
    adc_word  = w;
    conv_trig = 1'b1;
    n = 0;
    while (adc_cs_n === 1'b1 && n < 10) begin
      @(posedge clk); #1; n++;
    end
    conv_trig = 1'b0;
    check({tag, "_cs_lat"}, 32'(n), 32'd2);
    m = 0;
    while (data_valid !== 1'b1 && m < 400) begin
      @(posedge clk); #1; m++;
      if (m == inj_at) conv_trig = 1'b1;
      if (m == inj_at + 2) conv_trig = 1'b0;
      load = (m == load_at);
    end
    load = 1'b0;
    check({tag, "_dv_lat"}, 32'(m), 32'(LAT));
    check({tag, "_data"}, 32'(n_adc), 32'(w[11:0]));
    check({tag, "_sclk_falls"}, 32'(falls), 32'd16);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    @(posedge clk); #1;
    check({tag, "_dv_width"}, 32'(data_valid), 32'd0);
    check({tag, "_hold"}, 32'(n_adc), 32'(w[11:0]));
    repeat (period - n - m - 1) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] w;
    logic [3:0]  nib;
    int          k, cf;
    rst_n = 1'b0; conv_trig = 1'b0; load = 1'b0; adc_sdo = 1'b0;
    trig2 = 1'b0; sdo2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", 32'(adc_cs_n), 32'd1);
    check("rst_sclk", 32'(adc_sclk), 32'd1);
    check("rst_n_adc", 32'(n_adc), 32'd0);
    check("rst_dv", 32'(data_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_lead", 32'(lead_err), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    do_frame(16'h0A5C, 142, -1, -1, "single");
    check("single_lead", 32'(lead_err), 32'd0);

    min_gap = 1000;
    do_frame(16'h0000, 142, -1, -1, "p000");
    do_frame(16'h0FFF, 142, -1, -1, "pfff");
    do_frame(16'h0800, 142, -1, -1, "p800");
    do_frame(16'h0001, 142, -1, -1, "p001");
    for (int i = 0; i < 4; i++) begin
      w = {4'h0, 12'($urandom)};
      do_frame(w, 142 + $urandom_range(0, 20), -1, -1, "rand");
    end
    check("periodic_overrun", 32'(overrun), 32'd0);
    check("cs_quiet_min", 32'(min_gap >= QC), 32'd1);

    cf = cs_falls;
    do_frame(16'h0321, 0, 50, -1, "ovr");
    check("ovr_flag", 32'(overrun), 32'd1);
    repeat (300) @(posedge clk);
    #1;
    check("ovr_no_extra_frame", 32'(cs_falls), 32'(cf + 1));
    check("ovr_idle", 32'(busy), 32'd0);
    check("ovr_n_adc_held", 32'(n_adc), 32'h321);
    pulse_load();
    check("ovr_cleared", 32'(overrun), 32'd0);

    do_frame({4'b1010, 12'h123}, 142, -1, -1, "lead");
    check("lead_flag", 32'(lead_err), 32'd1);
    do_frame({4'b1000, 12'($urandom)}, 142, -1, 7, "lead_vs_load");
    check("lead_set_wins", 32'(lead_err), 32'd1);
    pulse_load();
    check("lead_cleared", 32'(lead_err), 32'd0);
    for (int i = 0; i < 4; i++) begin
      nib = 4'($urandom);
      do_frame({nib, 12'($urandom)}, 142, -1, -1, "lead_rand");
      check("lead_rand_flag", 32'(lead_err), 32'(nib != 4'h0));
      pulse_load();
    end

    adc_word = 16'h0BEE;
    conv_trig = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    conv_trig = 1'b0;
    k = 0;
    while (falls < 7 && k < 200) begin
      @(posedge clk); #1; k++;
    end
    check("mid_reached_edge7", 32'(falls), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_cs_n", 32'(adc_cs_n), 32'd1);
    check("mid_rst_sclk", 32'(adc_sclk), 32'd1);
    check("mid_rst_n_adc", 32'(n_adc), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    #3 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    do_frame(16'h0C0F, 142, -1, -1, "after_rst");

    word2 = {4'h0, 12'($urandom)};
    trig2 = 1'b1;
    k = 0;
    while (cs2 === 1'b1 && k < 10) begin
      @(posedge clk); #1; k++;
    end
    trig2 = 1'b0;
    check("div2_cs_lat", 32'(k), 32'd2);
    k = 0;
    while (dv2 !== 1'b1 && k < 200) begin
      @(posedge clk); #1; k++;
    end
    check("div2_dv_lat", 32'(k), 32'(LAT2));
    check("div2_data", 32'(n_adc2), 32'(word2[11:0]));
    check("div2_falls", 32'(falls2), 32'd16);
    check("div2_sclk_period", 32'(per2), 32'(2 * DIV2));
    check("div2_cs_high", 32'(cs2), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
